// File: rtl/inst_fetch_pkg.sv
// inst_fetch shared types and constants.
// Fetch/decode operand widths, FSM encoding, buffer entry layout.
package inst_fetch_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [XLEN-1:0] PC_INC       = 64'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~64'h3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch bus bundle: imem request side, redirect, decode handshake.
// master = fetch stage, slave = environment (imem + decode + redirect source).
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst, inst_pc, inst_valid,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_pc, inst_valid,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} with flush.
// Pointers carry one extra bit so full and empty differ.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH) + 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [AW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int IW = AW - 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign count  = wp - rp;
    assign empty  = (wp == rp);
    assign full   = (count == AW'(DEPTH));
    assign rdata  = mem[rp[IW-1:0]];

    // pointer update; flush discards everything
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
        end
    end

    // storage write, no reset needed on data
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wp[IW-1:0]] <= wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request, small buffer,
// redirect flush with DROP state to keep the imem handshake stable.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = DEF_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        CLK,
    input logic        RST,
    inst_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    logic            ack;
    logic            pop;
    logic            push;
    logic            room;
    logic            empty;
    logic            full;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occ_nxt;
    fetch_entry_t    wdata;
    fetch_entry_t    head;

    assign ack   = bus.imem_ack && (state_q != IDLE);
    assign pop   = !empty && bus.inst_ready;
    assign push  = ack && (state_q == BUSY) && !bus.redirect;
    assign wdata = '{pc: addr_q, inst: bus.imem_rdata};

    // occupancy after this edge; no request leaves us owing a slot
    assign occ_nxt = {1'b0, count} + OW'(push) - OW'(pop);
    assign room    = occ_nxt < OW'(FIFO_DEPTH);

    inst_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push && !full),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // next-state, request issue and fetch PC update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        if (bus.redirect) begin
            pc_d = word_align(bus.redirect_pc);
            if (state_q != IDLE) state_d = ack ? IDLE : DROP;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        state_d = BUSY;
                        addr_d  = pc_q;
                    end
                end
                BUSY: begin
                    if (ack) begin
                        pc_d = pc_q + PC_INC;
                        if (room) addr_d = pc_q + PC_INC;
                        else state_d = IDLE;
                    end
                end
                DROP: begin
                    if (ack) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, request address and fetch PC registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.imem_req   = (state_q != IDLE);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = !empty;
    assign bus.inst       = empty ? '0 : {{(XLEN-INST_W){1'b0}}, head.inst};
    assign bus.inst_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: imem responder, decode monitor,
// directed scenarios for streaming, backpressure, latency, redirect, reset.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    inst_fetch_if bus ();

    inst_fetch #(
        .RESET_PC   (64'h0000_0000_8000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          budget = 0;
    int          lat_q[$];
    int          hold_q[$];
    int          req_cyc_q[$];
    logic [63:0] req_addr_q[$];
    exp_t        exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mw(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_pc(input logic [63:0] p);
        exp_q.push_back('{pc: p, w: mw(p)});
    endtask

    task automatic wait_reqs(input int n, input string name);
        for (int i = 0; i < 200; i++) begin
            if (req_addr_q.size() >= n) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, got %0d requests want %0d",
                 name, req_addr_q.size(), n);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, %0d instructions outstanding want 0",
                 name, exp_q.size());
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b0;
        budget = 0;
        lat_q.delete();
        exp_q.delete();
        step();
        step();
        req_addr_q.delete();
        req_cyc_q.delete();
        hold_q.delete();
        RST = 1'b0;
    endtask

    // imem responder: logs each new request, holds for its latency, acks
    initial begin
        bit          busy;
        logic [63:0] held;
        int          wt;
        int          hold;
        busy = 1'b0;
        held = '0;
        wt = 0;
        hold = 0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge CLK);
            bus.imem_ack = 1'b0;
            if (RST) begin
                busy = 1'b0;
            end else if (bus.imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    held = bus.imem_addr;
                    req_addr_q.push_back(held);
                    req_cyc_q.push_back(cyc);
                    wt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                    hold = 0;
                end else begin
                    chk("addr_hold", bus.imem_addr, held);
                end
                hold++;
                if (wt == 0 && budget > 0) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mw(held);
                    budget--;
                    hold_q.push_back(hold);
                    busy = 1'b0;
                end else if (wt > 0) begin
                    wt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // decode-side monitor: every accepted instruction must match the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #4;
            if (!RST && bus.inst_valid && bus.inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, want none",
                             bus.inst_pc, bus.inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst", bus.inst, {32'b0, e.w});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        #1 RST = 1'b1;
        step();
        step();

        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", bus.imem_addr, 64'd0);
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst", bus.inst, 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);

        // stream with zero-wait memory, decode always ready
        budget = 3;
        expect_pc(64'h8000_0000);
        expect_pc(64'h8000_0004);
        expect_pc(64'h8000_0008);
        bus.inst_ready = 1'b1;
        RST = 1'b0;
        wait_reqs(3, "t1_reqs");
        wait_drain("t1_drain");
        chk("t1_req0", req_addr_q[0], 64'h8000_0000);
        chk("t1_req1", req_addr_q[1], 64'h8000_0004);
        chk("t1_req2", req_addr_q[2], 64'h8000_0008);
        chk("t1_b2b_a", 64'(req_cyc_q[1] - req_cyc_q[0]), 64'd1);
        chk("t1_b2b_b", 64'(req_cyc_q[2] - req_cyc_q[1]), 64'd1);

        // backpressure: buffer fills to two words, then fetch stops
        do_reset();
        budget = 3;
        repeat (8) step();
        chk("t2_nreq", 64'(req_addr_q.size()), 64'd2);
        chk("t2_req_low", 64'(bus.imem_req), 64'd0);
        chk("t2_valid", 64'(bus.inst_valid), 64'd1);
        chk("t2_head_pc", bus.inst_pc, 64'h8000_0000);
        chk("t2_req1", req_addr_q[1], 64'h8000_0004);
        expect_pc(64'h8000_0000);
        expect_pc(64'h8000_0004);
        expect_pc(64'h8000_0008);
        bus.inst_ready = 1'b1;
        wait_reqs(3, "t2_reqs");
        wait_drain("t2_drain");
        chk("t2_resume", req_addr_q[2], 64'h8000_0008);

        // three wait states per request
        do_reset();
        lat_q = '{3, 3};
        budget = 2;
        expect_pc(64'h8000_0000);
        expect_pc(64'h8000_0004);
        bus.inst_ready = 1'b1;
        wait_reqs(2, "t3_reqs");
        wait_drain("t3_drain");
        chk("t3_hold0", 64'(hold_q[0]), 64'd4);
        chk("t3_hold1", 64'(hold_q[1]), 64'd4);
        chk("t3_req1", req_addr_q[1], 64'h8000_0004);

        // redirect while a request to 0x..08 is still waiting
        do_reset();
        lat_q = '{0, 0, 4};
        budget = 4;
        expect_pc(64'h8000_0000);
        bus.inst_ready = 1'b1;
        wait_reqs(3, "t4_reqs");
        bus.inst_ready = 1'b0;
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h8000_1002;
        step();
        bus.redirect = 1'b0;
        chk("t4_flushed", 64'(bus.inst_valid), 64'd0);
        chk("t4_req_held", 64'(bus.imem_req), 64'd1);
        chk("t4_addr_held", bus.imem_addr, 64'h8000_0008);
        expect_pc(64'h8000_1000);
        bus.inst_ready = 1'b1;
        wait_reqs(4, "t4_reqs_new");
        wait_drain("t4_drain");
        chk("t4_new_req", req_addr_q[3], 64'h8000_1000);

        // redirect in the same cycle as the ack
        do_reset();
        lat_q = '{2};
        budget = 2;
        expect_pc(64'h8000_2004);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 50 && !bus.imem_ack; i++) step();
        chk("t5_ack_seen", 64'(bus.imem_ack), 64'd1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h8000_2007;
        step();
        bus.redirect = 1'b0;
        chk("t5_idle_req", 64'(bus.imem_req), 64'd0);
        chk("t5_valid", 64'(bus.inst_valid), 64'd0);
        step();
        chk("t5_req", 64'(bus.imem_req), 64'd1);
        chk("t5_addr", bus.imem_addr, 64'h8000_2004);
        wait_drain("t5_drain");

        // asynchronous reset with one word buffered and a request open
        do_reset();
        lat_q = '{0, 5};
        budget = 2;
        wait_reqs(2, "t6_reqs");
        step();
        chk("t6_pre_valid", 64'(bus.inst_valid), 64'd1);
        chk("t6_pre_req", 64'(bus.imem_req), 64'd1);
        RST = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.inst_valid), 64'd0);
        chk("t6_rst_req", 64'(bus.imem_req), 64'd0);
        chk("t6_rst_addr", bus.imem_addr, 64'd0);
        chk("t6_rst_inst", bus.inst, 64'd0);
        step();
        step();
        req_addr_q.delete();
        req_cyc_q.delete();
        hold_q.delete();
        lat_q.delete();
        exp_q.delete();
        budget = 1;
        expect_pc(64'h8000_0000);
        bus.inst_ready = 1'b1;
        RST = 1'b0;
        wait_reqs(1, "t6_reqs_post");
        wait_drain("t6_drain");
        chk("t6_first", req_addr_q[0], 64'h8000_0000);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
